lfsr_gen: RTL
=============

// Module: lfsr_gen
//
// PURPOSE
//   Parametrised LFSR pseudo-random generator. Width, tap mask, seed, structure
//   (Fibonacci/Galois) and shifts per clock are all parameters.
//   Adds clock enable, runtime seed load, all-zero lock-up recovery, and
//   sequence-wrap detection with a measured period.
//   Serves as the PRBS/scrambler source for datapath and test blocks.
//
// PARAMETERS
//   WIDTH  16       state width, >= 2
//   TAPS   16'hB400 tap mask, bit i = state[i] participates (see BEHAVIOUR)
//   SEED   16'h0001 reset / lock-up reload value, must be non-zero
//   GALOIS 0        0 = Fibonacci, 1 = Galois structure
//   STEPS  1        single shifts applied per enabled cycle, 1..WIDTH
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   en         in   1      advance the LFSR by STEPS shifts this cycle
//   load       in   1      load load_val into state (priority over en)
//   load_val   in   WIDTH  runtime seed
//   data_out   out  WIDTH  current LFSR state
//   bit_out    out  1      data_out[WIDTH-1], serial PRBS bit
//   lockup     out  1      1-cycle pulse: zero state detected and SEED reloaded
//   wrap       out  1      1-cycle pulse: state returned to start value
//   period     out  WIDTH  enabled-cycle count of the last completed wrap
//
// BEHAVIOUR
//   Reset (async, rst=1):
//     data_out = SEED; start = SEED; cnt = 0; period = 0; lockup = 0; wrap = 0.
//   One single shift s -> s':
//     Fibonacci: fb = ^(s & TAPS); s' = {s[WIDTH-2:0], fb}.
//     Galois: s' = {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS).
//     With WIDTH=4, TAPS=4'hC, Fibonacci gives fb = s[3]^s[2].
//   Enabled step: next = STEPS single shifts, chained combinationally.
//     Registered on the same edge, so latency is 1 clock.
//   Priority per rising edge (highest first):
//     load: state <= load_val; start <= load_val; cnt <= 0; no pulses.
//     en && state==0: state <= SEED; start <= SEED; cnt <= 0; lockup <= 1.
//       Lock-up is checked only on enabled cycles. A zero load holds until en.
//     en: state <= next; cnt <= cnt+1.
//       If next == start: wrap <= 1, period <= cnt+1, cnt <= 0.
//     idle (en=0): state, cnt, period hold; lockup and wrap <= 0.
//   lockup and wrap are registered and deassert the cycle after they pulse,
//     unless re-triggered.
//   cnt is WIDTH bits and wraps modulo 2^WIDTH. period is only valid if the
//     true period is < 2^WIDTH; a maximal-length LFSR gives 2^WIDTH-1.
//   Wrap compares only the post-step state. With STEPS>1 the start value may
//     be skipped; no wrap is then reported.
//   Reset mid-operation: immediately returns to reset values, whatever
//     en or load are doing.
//   bit_out is combinational from data_out. No other output depends
//     combinationally on inputs.
//
// TESTING (WIDTH=4, TAPS=4'hC, SEED=4'h1, GALOIS=0, STEPS=1 unless stated)
//   1. Reset, then en=1 for 15 cycles.
//      -> data_out = 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
//      -> wrap pulses on the cycle data_out returns to 1; period = 15.
//   2. en toggled 1,0,1 -> state advances only on en=1 cycles;
//      cnt/period unaffected by idle cycles.
//   3. load=1, load_val=4'h0, then en=1.
//      -> data_out = 0 after load.
//      -> next edge: data_out = 1, lockup = 1 for one cycle.
//   4. load and en both high with load_val=4'h6 -> data_out = 6, no advance.
//      Then 15 en cycles -> wrap on return to 6, period = 15.
//   5. Assert rst asynchronously mid-sequence, between clock edges.
//      -> data_out = 1 and wrap/lockup = 0 immediately; period = 0.
//   6. GALOIS=1 WIDTH=8 TAPS=8'h1D; STEPS=2 with the same parameters.
//      -> compare against a software model of the shift equations.
//      -> Galois (STEPS=1): period = 255 after 255 en cycles.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR pseudo-random generator (Fibonacci or Galois).
// The state advances by STEPS single shifts on each enabled cycle. A runtime
// seed can be loaded. An all-zero state is recovered by reloading SEED. A
// return to the start value is flagged, and the number of enabled cycles it
// took is reported as the period.
//
// Control semantics: load and en are sampled on every rising edge; there is
// no ready/back-pressure. load wins over en. A load of zero is held until the
// next enabled cycle, which recovers it to SEED and pulses lockup.
module lfsr_gen #(
  parameter int unsigned          WIDTH  = 16,
  parameter logic [WIDTH-1:0]     TAPS   = 16'hB400,
  parameter logic [WIDTH-1:0]     SEED   = 16'h0001,
  parameter bit                   GALOIS = 1'b0,
  parameter int unsigned          STEPS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data_out,
  output logic             bit_out,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] cnt_inc;

  // One single shift of the selected LFSR structure.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (GALOIS) begin
      r = {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS);
    end else begin
      r = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    return r;
  endfunction

  // Chain STEPS single shifts combinationally to form the enabled next state.
  always_comb begin
    nxt = state;
    for (int i = 0; i < int'(STEPS); i++) begin
      nxt = shift1(nxt);
    end
  end

  assign cnt_inc = cnt + ONE;

  // State, start value, cycle counter, period and the one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEED;
      start  <= SEED;
      cnt    <= '0;
      period <= '0;
      lockup <= 1'b0;
      wrap   <= 1'b0;
    end else if (load) begin
      state  <= load_val;
      start  <= load_val;
      cnt    <= '0;
      lockup <= 1'b0;
      wrap   <= 1'b0;
    end else if (en && (state == '0)) begin
      // A zero state never leaves zero on its own; restart from SEED.
      state  <= SEED;
      start  <= SEED;
      cnt    <= '0;
      lockup <= 1'b1;
      wrap   <= 1'b0;
    end else if (en) begin
      state  <= nxt;
      lockup <= 1'b0;
      if (nxt == start) begin
        wrap   <= 1'b1;
        period <= cnt_inc;
        cnt    <= '0;
      end else begin
        wrap   <= 1'b0;
        cnt    <= cnt_inc;
      end
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
    end
  end

  assign data_out = state;
  assign bit_out  = state[WIDTH-1];

endmodule
